csr_regfile_pmp: RTL and testbench
==================================

Name: csr_regfile_pmp

Overview:
- Next-generation Machine/User CSR file for the RV32 core, sitting beside the EX stage.
- Adds a parametrised PMP entry count, 64-bit mcycle/minstret counters, three interrupt sources with priority resolution, vectored mtvec, and illegal-access detection on the CSR port.
- Holds mstatus, mie, mip, mtvec, mscratch, mepc, mcause, mtval, misa, mhartid, pmpcfg*, pmpaddr*, counters and the current privilege level.
- Exports trap target, return address, interrupt request and PMP configuration to the pipeline and the PMP checker.

Parameters:
- PMP_ENTRIES, 4: number of PMP entries, legal range 0..16. pmpcfg registers implemented = ceil(PMP_ENTRIES/4).
- HAS_U_MODE, 1: 1 = U mode supported; 0 = machine-only.
- HART_ID, 0: value returned by mhartid.
- MISA_VAL, 32'h4000_0100: read-only misa value (RV32I). Bit 20 (U) is OR-ed in when HAS_U_MODE=1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- csr_addr  in  12  CSR address
- csr_op  in  csr_op_t  NONE/RW/RS/RC/RWI/RSI/RCI
- csr_wdata  in  32  rs1 value or zimm
- csr_no_write  in  1  RS/RC/RSI/RCI with rs1=x0 or zimm=0: read only, no write
- csr_rdata  out  32  read data (combinational)
- csr_illegal  out  1  current access is illegal (combinational)
- trap_enter  in  1  take trap this cycle
- trap_cause  in  32  mcause value; bit31 = interrupt
- trap_pc  in  32  value saved to mepc
- trap_val  in  32  value saved to mtval
- mret_exec  in  1  mret retires (pipeline guarantees priv=M)
- instr_retire  in  1  one instruction retired this cycle
- timer_irq, sw_irq, ext_irq  in  1 each  level-sensitive interrupt lines
- irq_pending  out  1  enabled interrupt present
- irq_cause  out  32  mcause value for the winning interrupt
- trap_target  out  32  PC to fetch on trap_enter
- mepc_out  out  32  mret return address
- priv_mode  out  2  current privilege
- pmpcfg_flat  out  8*PMP_ENTRIES  cfg byte i at bits [8i+7:8i]
- pmpaddr_flat  out  32*PMP_ENTRIES  pmpaddr i at bits [32i+31:32i]

Behaviour:
- Reset (async):
  - mstatus = 0x1800, priv = M.
  - All other writable CSRs, counters, and pmp registers = 0.
  - All outputs derived from these values: irq_pending = 0, trap_target = 0, mepc_out = 0.
- Address map:
  - mstatus 300, misa 301, mie 304, mtvec 305, mscratch 340, mepc 341, mcause 342, mtval 343, mip 344.
  - pmpcfg 3A0+k, pmpaddr 3B0+i.
  - mcycle B00/B80(h), minstret B02/B82(h).
  - cycle C00/C80, instret C02/C82 (read-only shadows).
  - mhartid F14.
  - Unimplemented pmp indices are unimplemented addresses.
- csr_illegal = csr_op != NONE and any of:
  - address unimplemented;
  - csr_addr[9:8] > priv_mode;
  - a write (RW/RWI, or a set/clear op with csr_no_write=0) to csr_addr[11:10]==2'b11.
- When csr_illegal=1: no state changes and csr_rdata = 0.
- Write value: RW = wdata; RS = old|wdata; RC = old&~wdata. Applied at the clock edge.
- Update priority: trap_enter > mret_exec > CSR write. Any lower-priority event in the same cycle is dropped.
- Trap entry:
  - mepc = trap_pc, mcause = trap_cause, mtval = trap_val.
  - MPIE = MIE, MIE = 0, MPP = priv, priv = M.
- mret:
  - MIE = MPIE, MPIE = 1, priv = MPP.
  - MPP = U if HAS_U_MODE, else M.
- mstatus writes: only MIE(3), MPIE(7) and MPP(12:11) are writable; all other bits read 0.
  - MPP is WARL: writing 01/10 keeps the old value.
  - When HAS_U_MODE=0, MPP reads 11 always.
- mepc writes clear bits [1:0].
- mtvec:
  - Written MODE 1x is stored as 00.
  - base = {mtvec[31:2], 2'b00}.
  - trap_target = base + 4*trap_cause[30:0] when MODE=01 and trap_cause[31]=1; otherwise base.
- mip: bits 3/7/11 = sw/timer/ext lines, read-only; writes to mip are ignored and are not illegal.
- mie: only bits 3, 7 and 11 are writable.
- Interrupts:
  - irq_pending = |(mip & mie) & (MIE | priv==U).
  - Priority ext(11) > sw(3) > timer(7).
  - irq_cause = {1'b1, 27'b0, code}, or 0 when no interrupt is pending.
- PMP cfg bytes:
  - Byte layout L[7], A[4:3], X[2], W[1], R[0]; bits 6:5 read 0.
  - R=0 with W=1 is stored as W=0.
  - Entry i is locked if L(i)=1. A locked entry ignores writes to its cfg byte and its pmpaddr.
  - pmpaddr i is also locked if entry i+1 has L=1 and A=TOR(01).
  - Locks are cleared only by reset.
- Counters:
  - mcycle increments every cycle.
  - minstret increments when instr_retire=1.
  - A write to either half of a counter replaces that half, keeps the other half, and suppresses that counter's increment in that cycle.
  - Wraps 0xFFFF_FFFF_FFFF_FFFF -> 0, with carry from the low half to the high half.
  - Counters keep counting during trap and mret cycles.

Test Plan:
- Reset, then read mstatus/misa/mhartid -> expect 0x1800, MISA_VAL|bit20, HART_ID. Write csrrw 0xF14 -> csr_illegal=1, mhartid unchanged.
- Write mtvec=0x1001 (vectored), mie=0x80, MIE=1, timer_irq=1 -> irq_pending=1, irq_cause=0x8000_0007. Pulse trap_enter with that cause -> trap_target=0x101C, priv=M, MIE=0, MPIE=1. Then mret -> MIE=1, priv=MPP.
- From U mode (after mret with MPP=00): read mstatus -> csr_illegal=1. Read cycle 0xC00 -> legal, returns the low counter value.
- PMP_ENTRIES=4: pmpcfg0=0x0000_8F00 (entry1 L, A=TOR, RWX) -> writes to pmpaddr0 and pmpaddr1 are ignored. Writing pmpcfg0 byte1 has no effect. Writing byte0 = 0x02 stores 0x00.
- Write mcycle=0xFFFF_FFFF with mcycleh=0 -> two cycles later mcycleh=1 and mcycle=1. Simultaneous instr_retire and a minstret write of 5 -> minstret=5.
- Same cycle trap_enter, mret_exec and a csrrw to mscratch -> only trap state changes, mscratch unchanged. Assert rst mid-operation -> all state returns to reset values immediately.

Source files
------------

// File: rtl/csr_regfile_pmp.sv
// RV32 Machine/User CSR file: trap/mret state, PMP registers, 64-bit counters and interrupt resolution.
// csr_op_i encoding: 0 NONE, 1 RW, 2 RS, 3 RC, 5 RWI, 6 RSI, 7 RCI (bit 2 only marks the zimm forms).
module csr_regfile_pmp #(
    parameter int          PMP_ENTRIES = 4,
    parameter bit          HAS_U_MODE  = 1'b1,
    parameter logic [31:0] HART_ID     = 32'h0,
    parameter logic [31:0] MISA_VAL    = 32'h4000_0100,
    localparam int         PE          = (PMP_ENTRIES > 0) ? PMP_ENTRIES : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [11:0]       csr_addr_i,
    input  logic [2:0]        csr_op_i,
    input  logic [31:0]       csr_wdata_i,
    input  logic              csr_no_write_i,
    output logic [31:0]       csr_rdata_o,
    output logic              csr_illegal_o,
    input  logic              trap_enter_i,
    input  logic [31:0]       trap_cause_i,
    input  logic [31:0]       trap_pc_i,
    input  logic [31:0]       trap_val_i,
    input  logic              mret_exec_i,
    input  logic              instr_retire_i,
    input  logic              timer_irq_i,
    input  logic              sw_irq_i,
    input  logic              ext_irq_i,
    output logic              irq_pending_o,
    output logic [31:0]       irq_cause_o,
    output logic [31:0]       trap_target_o,
    output logic [31:0]       mepc_out_o,
    output logic [1:0]        priv_mode_o,
    output logic [8*PE-1:0]   pmpcfg_flat_o,
    output logic [32*PE-1:0]  pmpaddr_flat_o
);

    localparam logic [1:0] PRIV_M = 2'b11;
    localparam logic [1:0] PRIV_U = 2'b00;

    logic [1:0]  priv_q, priv_d;
    logic        stMie_q, stMie_d, stMpie_q, stMpie_d;
    logic [1:0]  stMpp_q, stMpp_d;
    logic [31:0] mie_q, mie_d, mtvec_q, mtvec_d, mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
    logic [63:0] mcycle_q, mcycle_d, minstret_q, minstret_d;
    logic [7:0]  pmpcfg_q  [PE];
    logic [7:0]  pmpcfg_d  [PE];
    logic [31:0] pmpaddr_q [PE];
    logic [31:0] pmpaddr_d [PE];

    logic [31:0] mstatusRd, misaRd, mipRd, pendBits, rdRaw, wval, trapBase;
    logic        implemented, opValid, isWrite, illegal, csrWe;
    logic [PE-1:0] cfgLocked, addrLocked;
    logic [7:0]  cfgAbove;

    function automatic logic [7:0] sanitizeCfg(input logic [7:0] b);
        return {b[7], 2'b00, b[4:3], b[2], b[1] & b[0], b[0]};
    endfunction

    function automatic logic mppLegal(input logic [1:0] v);
        return (v == PRIV_M) || (HAS_U_MODE && (v == PRIV_U));
    endfunction

    assign mstatusRd = {19'b0, (HAS_U_MODE ? stMpp_q : PRIV_M), 3'b0, stMpie_q, 3'b0, stMie_q, 3'b0};
    assign misaRd    = MISA_VAL | (HAS_U_MODE ? 32'h0010_0000 : 32'h0);
    assign mipRd     = {20'b0, ext_irq_i, 3'b0, timer_irq_i, 3'b0, sw_irq_i, 3'b0};

    // An entry's address is also frozen when the next entry is a locked TOR entry using it as bottom.
    always_comb begin
        for (int i = 0; i < PE; i++) begin
            cfgAbove      = (i + 1 < PE) ? pmpcfg_q[(i + 1) % PE] : 8'h00;
            cfgLocked[i]  = pmpcfg_q[i][7];
            addrLocked[i] = pmpcfg_q[i][7] | (cfgAbove[7] & (cfgAbove[4:3] == 2'b01));
        end
    end

    always_comb begin
        rdRaw       = '0;
        implemented = 1'b1;
        case (csr_addr_i)
            12'h300:          rdRaw = mstatusRd;
            12'h301:          rdRaw = misaRd;
            12'h304:          rdRaw = mie_q;
            12'h305:          rdRaw = mtvec_q;
            12'h340:          rdRaw = mscratch_q;
            12'h341:          rdRaw = mepc_q;
            12'h342:          rdRaw = mcause_q;
            12'h343:          rdRaw = mtval_q;
            12'h344:          rdRaw = mipRd;
            12'hB00, 12'hC00: rdRaw = mcycle_q[31:0];
            12'hB80, 12'hC80: rdRaw = mcycle_q[63:32];
            12'hB02, 12'hC02: rdRaw = minstret_q[31:0];
            12'hB82, 12'hC82: rdRaw = minstret_q[63:32];
            12'hF14:          rdRaw = HART_ID;
            default:          implemented = 1'b0;
        endcase
        for (int i = 0; i < PE; i++) begin
            if (i < PMP_ENTRIES) begin
                if (csr_addr_i == 12'h3A0 + 12'(i / 4)) begin
                    implemented = 1'b1;
                    rdRaw[8*(i%4) +: 8] = pmpcfg_q[i];
                end
                if (csr_addr_i == 12'h3B0 + 12'(i)) begin
                    implemented = 1'b1;
                    rdRaw = pmpaddr_q[i];
                end
            end
        end
    end

    always_comb begin
        opValid = csr_op_i[1:0] != 2'b00;
        isWrite = opValid && ((csr_op_i[1:0] == 2'b01) || !csr_no_write_i);
        illegal = opValid && (!implemented || (csr_addr_i[9:8] > priv_q) ||
                              (isWrite && (csr_addr_i[11:10] == 2'b11)));
        csrWe   = isWrite && !illegal && !trap_enter_i && !mret_exec_i;
        case (csr_op_i[1:0])
            2'b10:   wval = rdRaw | csr_wdata_i;
            2'b11:   wval = rdRaw & ~csr_wdata_i;
            default: wval = csr_wdata_i;
        endcase
    end

    assign csr_illegal_o = illegal;
    assign csr_rdata_o   = illegal ? 32'h0 : rdRaw;

    // Trap beats mret beats CSR write; counters advance regardless of which one wins.
    always_comb begin
        priv_d     = priv_q;
        stMie_d    = stMie_q;
        stMpie_d   = stMpie_q;
        stMpp_d    = stMpp_q;
        mie_d      = mie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        mcycle_d   = mcycle_q + 64'd1;
        minstret_d = minstret_q + {63'b0, instr_retire_i};
        for (int i = 0; i < PE; i++) begin
            pmpcfg_d[i]  = pmpcfg_q[i];
            pmpaddr_d[i] = pmpaddr_q[i];
        end
        if (trap_enter_i) begin
            mepc_d   = trap_pc_i;
            mcause_d = trap_cause_i;
            mtval_d  = trap_val_i;
            stMpie_d = stMie_q;
            stMie_d  = 1'b0;
            stMpp_d  = HAS_U_MODE ? priv_q : PRIV_M;
            priv_d   = PRIV_M;
        end else if (mret_exec_i) begin
            stMie_d  = stMpie_q;
            stMpie_d = 1'b1;
            priv_d   = HAS_U_MODE ? stMpp_q : PRIV_M;
            stMpp_d  = HAS_U_MODE ? PRIV_U : PRIV_M;
        end
        if (csrWe) begin
            case (csr_addr_i)
                12'h300: begin
                    stMie_d  = wval[3];
                    stMpie_d = wval[7];
                    if (mppLegal(wval[12:11])) stMpp_d = wval[12:11];
                end
                12'h304: mie_d      = wval & 32'h0000_0888;
                12'h305: mtvec_d    = {wval[31:2], wval[1] ? 2'b00 : wval[1:0]};
                12'h340: mscratch_d = wval;
                12'h341: mepc_d     = {wval[31:2], 2'b00};
                12'h342: mcause_d   = wval;
                12'h343: mtval_d    = wval;
                12'hB00: mcycle_d   = {mcycle_q[63:32], wval};
                12'hB80: mcycle_d   = {wval, mcycle_q[31:0]};
                12'hB02: minstret_d = {minstret_q[63:32], wval};
                12'hB82: minstret_d = {wval, minstret_q[31:0]};
                default: ;
            endcase
            for (int i = 0; i < PE; i++) begin
                if (i < PMP_ENTRIES) begin
                    if ((csr_addr_i == 12'h3A0 + 12'(i / 4)) && !cfgLocked[i])
                        pmpcfg_d[i] = sanitizeCfg(wval[8*(i%4) +: 8]);
                    if ((csr_addr_i == 12'h3B0 + 12'(i)) && !addrLocked[i])
                        pmpaddr_d[i] = wval;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            priv_q     <= PRIV_M;
            stMie_q    <= 1'b0;
            stMpie_q   <= 1'b0;
            stMpp_q    <= PRIV_M;
            mie_q      <= '0;
            mtvec_q    <= '0;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
            mcycle_q   <= '0;
            minstret_q <= '0;
            for (int i = 0; i < PE; i++) begin
                pmpcfg_q[i]  <= '0;
                pmpaddr_q[i] <= '0;
            end
        end else begin
            priv_q     <= priv_d;
            stMie_q    <= stMie_d;
            stMpie_q   <= stMpie_d;
            stMpp_q    <= stMpp_d;
            mie_q      <= mie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
            for (int i = 0; i < PE; i++) begin
                pmpcfg_q[i]  <= pmpcfg_d[i];
                pmpaddr_q[i] <= pmpaddr_d[i];
            end
        end
    end

    // Interrupt priority: external, then software, then timer.
    always_comb begin
        pendBits      = mipRd & mie_q;
        irq_pending_o = (|pendBits) && (stMie_q || (priv_q == PRIV_U));
        irq_cause_o   = 32'h0;
        if (irq_pending_o) begin
            if (pendBits[11])     irq_cause_o = {1'b1, 27'b0, 4'd11};
            else if (pendBits[3]) irq_cause_o = {1'b1, 27'b0, 4'd3};
            else                  irq_cause_o = {1'b1, 27'b0, 4'd7};
        end
    end

    always_comb begin
        trapBase = {mtvec_q[31:2], 2'b00};
        if ((mtvec_q[1:0] == 2'b01) && trap_cause_i[31])
            trap_target_o = trapBase + {trap_cause_i[29:0], 2'b00};
        else
            trap_target_o = trapBase;
        for (int i = 0; i < PE; i++) begin
            pmpcfg_flat_o[8*i +: 8]   = pmpcfg_q[i];
            pmpaddr_flat_o[32*i +: 32] = pmpaddr_q[i];
        end
    end

    assign mepc_out_o  = mepc_q;
    assign priv_mode_o = priv_q;

endmodule

// File: tb/tb_csr_regfile_pmp.sv
// Directed scoreboard bench for csr_regfile_pmp (default 4 PMP entries, U mode, hart id 5).
module tb_csr_regfile_pmp;

    localparam logic [2:0] OP_NONE = 3'd0;
    localparam logic [2:0] OP_RW   = 3'd1;
    localparam logic [2:0] OP_RS   = 3'd2;
    localparam logic [2:0] OP_RC   = 3'd3;
    localparam logic [2:0] OP_RSI  = 3'd6;

    logic         clk = 1'b0;
    logic         rst;
    logic [11:0]  csrAddr;
    logic [2:0]   csrOp;
    logic [31:0]  csrWdata;
    logic         csrNoWrite;
    logic [31:0]  csrRdata;
    logic         csrIllegal;
    logic         trapEnter;
    logic [31:0]  trapCause, trapPc, trapVal;
    logic         mretExec, instrRetire, timerIrq, swIrq, extIrq;
    logic         irqPending;
    logic [31:0]  irqCause, trapTarget, mepcOut;
    logic [1:0]   privMode;
    logic [31:0]  pmpcfgFlat;
    logic [127:0] pmpaddrFlat;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } expItem_t;
    expItem_t scoreboard[$];

    csr_regfile_pmp #(.PMP_ENTRIES(4), .HAS_U_MODE(1'b1), .HART_ID(32'h5), .MISA_VAL(32'h4000_0100)) dut (
        .clk(clk), .rst(rst),
        .csr_addr_i(csrAddr), .csr_op_i(csrOp), .csr_wdata_i(csrWdata), .csr_no_write_i(csrNoWrite),
        .csr_rdata_o(csrRdata), .csr_illegal_o(csrIllegal),
        .trap_enter_i(trapEnter), .trap_cause_i(trapCause), .trap_pc_i(trapPc), .trap_val_i(trapVal),
        .mret_exec_i(mretExec), .instr_retire_i(instrRetire),
        .timer_irq_i(timerIrq), .sw_irq_i(swIrq), .ext_irq_i(extIrq),
        .irq_pending_o(irqPending), .irq_cause_o(irqCause), .trap_target_o(trapTarget),
        .mepc_out_o(mepcOut), .priv_mode_o(privMode),
        .pmpcfg_flat_o(pmpcfgFlat), .pmpaddr_flat_o(pmpaddrFlat)
    );

    always #50 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [11:0] addr, input logic [2:0] op,
                                 input logic [31:0] data, input logic noWrite);
        csrAddr    = addr;
        csrOp      = op;
        csrWdata   = data;
        csrNoWrite = noWrite;
    endtask

    task automatic expectValue(input string tag, input logic [31:0] exp);
        scoreboard.push_back('{tag: tag, exp: exp});
    endtask

    task automatic checkOutput(input logic [31:0] obs);
        expItem_t e;
        checks++;
        if (scoreboard.size() == 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_underflow observed %h expected a queued value", obs);
            return;
        end
        e = scoreboard.pop_front();
        assert (obs === e.exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %h expected %h", e.tag, obs, e.exp);
        end
    endtask

    task automatic checkSig(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        expectValue(tag, exp);
        checkOutput(obs);
    endtask

    task automatic csrWrite(input logic [11:0] addr, input logic [2:0] op,
                            input logic [31:0] data, input logic noWrite);
        applyStimulus(addr, op, data, noWrite);
        tick();
        csrOp = OP_NONE;
    endtask

    task automatic readCsr(input string tag, input logic [11:0] addr, input logic [31:0] exp);
        applyStimulus(addr, OP_RS, 32'h0, 1'b1);
        expectValue(tag, exp);
        #1;
        checkOutput(csrRdata);
        csrOp = OP_NONE;
    endtask

    task automatic readIllegal(input string tag, input logic [11:0] addr);
        applyStimulus(addr, OP_RS, 32'h0, 1'b1);
        expectValue(tag, 32'h1);
        #1;
        checkOutput({31'b0, csrIllegal});
        csrOp = OP_NONE;
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(12'h0, OP_NONE, 32'h0, 1'b0);
        trapEnter = 0; trapCause = 0; trapPc = 0; trapVal = 0;
        mretExec = 0; instrRetire = 0; timerIrq = 0; swIrq = 0; extIrq = 0;
        #120;
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Reset state and read-only machine information
        readCsr("mstatus_reset", 12'h300, 32'h0000_1800);
        readCsr("misa", 12'h301, 32'h4010_0100);
        readCsr("mhartid", 12'hF14, 32'h0000_0005);
        checkSig("priv_reset", {30'b0, privMode}, 32'h3);
        checkSig("irq_pending_reset", {31'b0, irqPending}, 32'h0);
        checkSig("trap_target_reset", trapTarget, 32'h0);
        checkSig("mepc_out_reset", mepcOut, 32'h0);

        applyStimulus(12'hF14, OP_RW, 32'h1234, 1'b0);
        #1;
        checkSig("mhartid_write_illegal", {31'b0, csrIllegal}, 32'h1);
        checkSig("illegal_rdata_zero", csrRdata, 32'h0);
        tick();
        csrOp = OP_NONE;
        readCsr("mhartid_unchanged", 12'hF14, 32'h0000_0005);
        readIllegal("pmpcfg1_unimpl", 12'h3A1);
        readIllegal("pmpaddr4_unimpl", 12'h3B4);
        applyStimulus(12'h344, OP_RW, 32'hFFFF_FFFF, 1'b0);
        #1;
        checkSig("mip_write_legal", {31'b0, csrIllegal}, 32'h0);
        tick();
        csrOp = OP_NONE;
        readCsr("mip_write_ignored", 12'h344, 32'h0);

        // Vectored timer interrupt and trap entry
        csrWrite(12'h305, OP_RW, 32'h0000_1001, 1'b0);
        readCsr("mtvec_vectored", 12'h305, 32'h0000_1001);
        csrWrite(12'h304, OP_RW, 32'hFFFF_FFFF, 1'b0);
        readCsr("mie_mask", 12'h304, 32'h0000_0888);
        csrWrite(12'h304, OP_RW, 32'h0000_0080, 1'b0);
        csrWrite(12'h300, OP_RS, 32'h0000_0008, 1'b0);
        readCsr("mstatus_mie_set", 12'h300, 32'h0000_1808);
        timerIrq = 1'b1;
        #1;
        checkSig("timer_pending", {31'b0, irqPending}, 32'h1);
        checkSig("timer_cause", irqCause, 32'h8000_0007);
        readCsr("mip_timer", 12'h344, 32'h0000_0080);

        applyStimulus(12'h340, OP_RW, 32'h0000_DEAD, 1'b0);
        trapEnter = 1'b1; mretExec = 1'b1;
        trapCause = 32'h8000_0007; trapPc = 32'h0000_2000; trapVal = 32'h55;
        #1;
        checkSig("trap_target_vectored", trapTarget, 32'h0000_101C);
        tick();
        trapEnter = 1'b0; mretExec = 1'b0; csrOp = OP_NONE;
        readCsr("mstatus_after_trap", 12'h300, 32'h0000_1880);
        checkSig("priv_after_trap", {30'b0, privMode}, 32'h3);
        checkSig("mepc_out_trap", mepcOut, 32'h0000_2000);
        readCsr("mcause_trap", 12'h342, 32'h8000_0007);
        readCsr("mtval_trap", 12'h343, 32'h0000_0055);
        readCsr("mscratch_dropped", 12'h340, 32'h0);
        checkSig("irq_masked_in_trap", {31'b0, irqPending}, 32'h0);

        // mret back to M, then mret into U
        mretExec = 1'b1;
        tick();
        mretExec = 1'b0;
        readCsr("mstatus_after_mret", 12'h300, 32'h0000_0088);
        checkSig("priv_after_mret1", {30'b0, privMode}, 32'h3);
        checkSig("irq_after_mret", {31'b0, irqPending}, 32'h1);
        csrWrite(12'hB00, OP_RW, 32'h0000_0100, 1'b0);
        mretExec = 1'b1;
        tick();
        mretExec = 1'b0;
        checkSig("priv_user", {30'b0, privMode}, 32'h0);
        readCsr("cycle_from_user", 12'hC00, 32'h0000_0101);
        readIllegal("mstatus_from_user", 12'h300);
        readIllegal("mcycle_from_user", 12'hB00);

        // Asynchronous reset in the middle of a cycle
        #20;
        rst = 1'b1;
        trapCause = 32'h8000_0007;
        #1;
        checkSig("rst_priv", {30'b0, privMode}, 32'h3);
        checkSig("rst_mepc", mepcOut, 32'h0);
        checkSig("rst_trap_target", trapTarget, 32'h0);
        checkSig("rst_irq", {31'b0, irqPending}, 32'h0);
        readCsr("rst_mstatus", 12'h300, 32'h0000_1800);
        timerIrq = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Field legalisation: mepc, mtvec mode, MPP WARL
        csrWrite(12'h341, OP_RW, 32'h0000_1237, 1'b0);
        readCsr("mepc_align", 12'h341, 32'h0000_1234);
        checkSig("mepc_out_align", mepcOut, 32'h0000_1234);
        csrWrite(12'h305, OP_RW, 32'h0000_2003, 1'b0);
        readCsr("mtvec_mode_1x", 12'h305, 32'h0000_2000);
        csrWrite(12'h300, OP_RW, 32'h0000_1000, 1'b0);
        readCsr("mpp_warl_keep", 12'h300, 32'h0000_1800);
        csrWrite(12'h300, OP_RC, 32'h0000_1800, 1'b0);
        readCsr("mpp_to_user", 12'h300, 32'h0);
        csrWrite(12'h300, OP_RS, 32'h0000_0008, 1'b1);
        readCsr("no_write_set", 12'h300, 32'h0);
        csrWrite(12'h300, OP_RSI, 32'h0000_0008, 1'b0);
        readCsr("rsi_mie", 12'h300, 32'h0000_0008);

        // Interrupt priority
        csrWrite(12'h304, OP_RW, 32'h0000_0FFF, 1'b0);
        timerIrq = 1'b1; swIrq = 1'b1;
        #1;
        checkSig("sw_over_timer", irqCause, 32'h8000_0003);
        extIrq = 1'b1;
        trapCause = 32'h8000_000B;
        #1;
        checkSig("ext_over_all", irqCause, 32'h8000_000B);
        checkSig("direct_trap_target", trapTarget, 32'h0000_2000);
        timerIrq = 1'b0; swIrq = 1'b0; extIrq = 1'b0;

        // PMP locking and cfg legalisation
        csrWrite(12'h3B0, OP_RW, 32'h0000_1111, 1'b0);
        csrWrite(12'h3B1, OP_RW, 32'h0000_2222, 1'b0);
        csrWrite(12'h3A0, OP_RW, 32'h0000_8F00, 1'b0);
        readCsr("pmpcfg0_lock", 12'h3A0, 32'h0000_8F00);
        csrWrite(12'h3B0, OP_RW, 32'h0000_AAAA, 1'b0);
        readCsr("pmpaddr0_tor_locked", 12'h3B0, 32'h0000_1111);
        csrWrite(12'h3B1, OP_RW, 32'h0000_BBBB, 1'b0);
        readCsr("pmpaddr1_locked", 12'h3B1, 32'h0000_2222);
        csrWrite(12'h3A0, OP_RW, 32'h0000_0002, 1'b0);
        readCsr("pmpcfg0_w_without_r", 12'h3A0, 32'h0000_8F00);
        csrWrite(12'h3A0, OP_RW, 32'h0000_006D, 1'b0);
        readCsr("pmpcfg0_reserved_bits", 12'h3A0, 32'h0000_8F0D);
        csrWrite(12'h3B2, OP_RW, 32'h0000_0033, 1'b0);
        readCsr("pmpaddr2_free", 12'h3B2, 32'h0000_0033);
        checkSig("pmpcfg_flat", pmpcfgFlat, 32'h0000_8F0D);
        checkSig("pmpaddr_flat1", pmpaddrFlat[63:32], 32'h0000_2222);

        // Counters: carry across halves and write-beats-increment
        csrWrite(12'hB80, OP_RW, 32'h0, 1'b0);
        csrWrite(12'hB00, OP_RW, 32'hFFFF_FFFF, 1'b0);
        tick();
        tick();
        readCsr("mcycleh_carry", 12'hB80, 32'h0000_0001);
        readCsr("mcycle_wrapped", 12'hB00, 32'h0000_0001);
        readCsr("cycleh_shadow", 12'hC80, 32'h0000_0001);
        instrRetire = 1'b1;
        csrWrite(12'hB02, OP_RW, 32'h0000_0005, 1'b0);
        instrRetire = 1'b0;
        readCsr("minstret_write_wins", 12'hB02, 32'h0000_0005);
        instrRetire = 1'b1;
        tick();
        tick();
        instrRetire = 1'b0;
        readCsr("minstret_count", 12'hB02, 32'h0000_0007);
        readCsr("instreth_shadow", 12'hC82, 32'h0);

        checks++;
        assert (scoreboard.size() == 0) else begin
            errors++;
            $error("[TB] FAIL scoreboard_drain observed %0d expected 0", scoreboard.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
